// File: rtl/vec_pkg.sv
// Shared defaults, lane-vector type and FSM state encoding for the duplex sequencer.
package vec_pkg;

  localparam int N_DEF = 8;
  localparam int V_DEF = 16;

  typedef logic [V_DEF-1:0][N_DEF-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    LO   = 2'd2,
    HI   = 2'd3
  } state_t;

endpackage

// File: rtl/lane_dup_half.sv
// Combinational lane duplicator: each lane of the selected half of vec is
// written to two adjacent output lanes (half=0 -> low half, half=1 -> high half).
module lane_dup_half
  import vec_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int V = V_DEF
) (
  input  logic [V-1:0][N-1:0] vec,
  input  logic                half,
  output logic [V-1:0][N-1:0] dup
);

  logic [N-1:0] lane;

  always_comb begin
    dup  = '0;
    lane = '0;
    for (int i = 0; i < V / 2; i++) begin
      lane         = half ? vec[i + V / 2] : vec[i];
      dup[2*i]     = lane;
      dup[2*i + 1] = lane;
    end
  end

endmodule

// File: rtl/duplex_sequencer.sv
// Accepts one V-lane vector at a time and emits it either unchanged (one beat)
// or as two duplicated half beats (low half, then high half).
module duplex_sequencer
  import vec_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int V = V_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [V-1:0][N-1:0] in_vec,
  input  logic                dup_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [V-1:0][N-1:0] out_vec,
  output logic                out_half,
  output logic                out_last,
  output logic [15:0]         vec_count,
  output state_t              fsm_state
);

  // Handshakes (both sides): a transfer happens on a rising edge where valid
  // and ready are both high; a valid beat holds its payload until taken.

  state_t                state_q;
  state_t                state_d;
  logic [V-1:0][N-1:0]   held_q;
  logic [V-1:0][N-1:0]   dup_vec;
  logic [15:0]           count_q;
  logic                  accept;
  logic                  out_fire;
  logic                  final_fire;

  lane_dup_half #(
    .N(N),
    .V(V)
  ) u_dup (
    .vec (held_q),
    .half(state_q == HI),
    .dup (dup_vec)
  );

  always_comb begin
    out_valid  = (state_q != IDLE);
    out_half   = (state_q == HI);
    out_last   = (state_q == PASS) || (state_q == HI);
    out_vec    = (state_q == PASS) ? held_q : dup_vec;
    out_fire   = out_valid && out_ready;
    final_fire = out_fire && out_last;
    // A new vector may enter on the same edge its predecessor's final beat leaves.
    in_ready   = (state_q == IDLE) || (out_last && out_ready);
    accept     = in_valid && in_ready;

    state_d = state_q;
    if (accept) begin
      state_d = dup_en ? LO : PASS;
    end else if (final_fire) begin
      state_d = IDLE;
    end else if ((state_q == LO) && out_fire) begin
      state_d = HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        held_q <= in_vec;
      end
      if (final_fire) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign vec_count = count_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_duplex_sequencer.sv
// Self-checking bench for duplex_sequencer: directed scenarios plus a
// queue-based beat model fed from observed input handshakes.
module tb_duplex_sequencer;
  import vec_pkg::*;

  localparam int N = 8;
  localparam int V = 16;
  localparam int W = V * N + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [V-1:0][N-1:0] in_vec = '0;
  logic                dup_en = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [V-1:0][N-1:0] out_vec;
  logic                out_half;
  logic                out_last;
  logic [15:0]         vec_count;
  state_t              fsm_state;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] m_count = '0;

  duplex_sequencer #(.N(N), .V(V)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .dup_en   (dup_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec  (out_vec),
    .out_half (out_half),
    .out_last (out_last),
    .vec_count(vec_count),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // kind 0 = pass beat, 1 = low-half beat, 2 = high-half beat
  function automatic logic [V-1:0][N-1:0] model_beat(input logic [V-1:0][N-1:0] v, input int kind);
    logic [V-1:0][N-1:0] r;
    for (int j = 0; j < V; j++) begin
      int src;
      src = (kind == 0) ? j : (j / 2) + ((kind == 2) ? V / 2 : 0);
      r[j] = v[src];
    end
    return r;
  endfunction

  function automatic logic [V-1:0][N-1:0] rand_vec();
    logic [V-1:0][N-1:0] r;
    for (int j = 0; j < V; j++) r[j] = N'($urandom_range(0, 255));
    return r;
  endfunction

  // Scoreboard: expected beats of the vector in flight, layout {half, last, vec}.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_count = '0;
    end else begin
      logic         exp_rdy;
      logic [W-1:0] head;
      checks++;
      if (vec_count !== m_count) begin
        errors++;
        $display("FAIL sb_count: got %h expected %h at %0t", vec_count, m_count, $time);
      end
      exp_rdy = (exp_q.size() == 0) ? 1'b1 : (exp_q[0][V*N] && out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid: got %b expected %b at %0t", out_valid, exp_q.size() != 0, $time);
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        head = exp_q[0];
        checks++;
        if ({out_half, out_last, out_vec} !== head) begin
          errors++;
          $display("FAIL sb_beat: got %h expected %h at %0t", {out_half, out_last, out_vec}, head, $time);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (head[V*N]) m_count++;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        if (dup_en) begin
          exp_q.push_back({1'b0, 1'b0, model_beat(in_vec, 1)});
          exp_q.push_back({1'b1, 1'b1, model_beat(in_vec, 2)});
        end else begin
          exp_q.push_back({1'b0, 1'b1, model_beat(in_vec, 0)});
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dup_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid %b count %h ready %b, expected 0 0000 1", out_valid, vec_count, in_ready);
    end
  endtask

  task automatic test_duplex();
    logic [V-1:0][N-1:0] lo_e, hi_e;
    do_reset();
    for (int k = 0; k < V; k++) begin
      in_vec[k] = N'(k);
      lo_e[k]   = N'(k / 2);
      hi_e[k]   = N'(8 + k / 2);
    end
    dup_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== lo_e || out_half !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL duplex_lo: got v%b h%b l%b %h expected v1 h0 l0 %h", out_valid, out_half, out_last, out_vec, lo_e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== hi_e || out_half !== 1'b1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL duplex_hi: got v%b h%b l%b %h expected v1 h1 l1 %h", out_valid, out_half, out_last, out_vec, hi_e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd1) begin
      errors++;
      $display("FAIL duplex_done: valid %b count %h expected 0 0001", out_valid, vec_count);
    end
  endtask

  task automatic test_pass();
    logic [V-1:0][N-1:0] a;
    do_reset();
    for (int k = 0; k < V; k++) a[k] = N'(8'hA0 + k);
    in_vec = a; dup_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== a || out_half !== 1'b0 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL pass_beat: got v%b h%b l%b %h expected v1 h0 l1 %h", out_valid, out_half, out_last, out_vec, a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd1) begin
      errors++;
      $display("FAIL pass_done: valid %b count %h expected 0 0001", out_valid, vec_count);
    end
  endtask

  task automatic test_backpressure();
    logic [V-1:0][N-1:0] a;
    do_reset();
    a = rand_vec();
    in_vec = a; dup_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_vec = rand_vec(); dup_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_vec !== model_beat(a, 1) || out_half !== 1'b0 ||
          out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: v%b h%b l%b rdy%b %h expected v1 h0 l0 rdy0 %h", c, out_valid,
                 out_half, out_last, in_ready, out_vec, model_beat(a, 1));
      end
      @(posedge clk); #1;
      in_vec = rand_vec();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== model_beat(a, 2) || out_half !== 1'b1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_hi: v%b h%b l%b %h expected v1 h1 l1 %h", out_valid, out_half, out_last,
               out_vec, model_beat(a, 2));
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (vec_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_count: got %h expected 0001", vec_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [V-1:0][N-1:0] a, b;
    do_reset();
    a = rand_vec(); b = rand_vec();
    in_vec = a; dup_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_vec = b; dup_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_half !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hi_ready: ready %b half %b expected 1 1", in_ready, out_half);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== b || out_half !== 1'b0 || out_last !== 1'b1 || vec_count !== 16'd1) begin
      errors++;
      $display("FAIL b2b_pass: v%b h%b l%b cnt %h %h expected v1 h0 l1 cnt 0001 %h", out_valid, out_half,
               out_last, vec_count, out_vec, b);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_done: valid %b count %h expected 0 0002", out_valid, vec_count);
    end
  endtask

  task automatic test_rst_mid();
    logic [V-1:0][N-1:0] a, b;
    do_reset();
    a = rand_vec(); b = rand_vec();
    in_vec = a; dup_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_half !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: half %b valid %b expected 1 1", out_half, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_post: valid %b count %h ready %b expected 0 0000 1", out_valid, vec_count, in_ready);
    end
    @(posedge clk); #1;
    in_vec = b; dup_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== b || out_last !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_next: v%b l%b %h expected v1 l1 %h", out_valid, out_last, out_vec, b);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (vec_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_count: got %h expected 0001", vec_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_vec    = rand_vec();
      dup_en    = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int acc;
    int cyc;
    do_reset();
    acc = 0; cyc = 0;
    in_vec = rand_vec(); dup_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    while (acc < 65536 && cyc < 70000) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc++;
      @(posedge clk); #1;
      cyc++;
      if (acc == 65536) in_valid = 1'b0;
      else in_vec = rand_vec();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 65536) begin
      errors++;
      $display("FAIL wrap_accepts: got %0d expected 65536 within %0d cycles", acc, cyc);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || vec_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre: v%b l%b count %h expected v1 l1 ffff", out_valid, out_last, vec_count);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (vec_count !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: count %h valid %b expected 0000 0", vec_count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_duplex();
    test_pass();
    test_backpressure();
    test_back_to_back();
    test_rst_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
